usb_tx_sequencer: RTL and testbench

//  Transmit-side packet sequencer for the USB serial TX path (crc -> bit_stuff -> nrzi).

---
 rtl/usb_pkg.sv | 41 ++++
 rtl/usb_tx_shifter.sv | 26 ++
 rtl/usb_tx_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit sequencer.
// PID nibbles are the 4-bit codes; the wire byte is {~pid, pid}.
package usb_pkg;

    typedef enum logic [1:0] {
        KIND_NONE      = 2'b00,
        KIND_TOKEN     = 2'b01,
        KIND_DATA      = 2'b10,
        KIND_HANDSHAKE = 2'b11
    } pkt_kind_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_CSTART,
        ST_LOAD,
        ST_FIELD,
        ST_CEND,
        ST_WAIT_CRC,
        ST_WAIT_LINE
    } tx_state_t;

    // Sent LSB first: seven zeros then a one.
    localparam logic [7:0] SYNC_PATTERN     = 8'h80;
    localparam int         TOKEN_FIELD_BITS = 11;

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_shifter.sv
// 16-bit LSB-first shift register feeding the serial bit; load wins over advance,
// and with neither asserted the current bit holds.
module usb_tx_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        advance,
    output logic        bit_out
);

    logic [15:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (advance) begin
            sr <= {1'b0, sr[15:1]};
        end
    end

    assign bit_out = sr[0];

endmodule

// File: rtl/usb_tx_sequencer.sv
// Transmit packet sequencer: SYNC, PID and CRC-covered field serialised into the crc unit,
// then waits for CRC append and EOP before accepting the next request.
//
// state        | meaning
// IDLE         | ready for a request
// SYNC         | shifting the 8 sync bits
// PID          | shifting {~pid, pid}
// CSTART       | crc_start strobe, pkt_in = kind
// LOAD         | sample next DATA byte (byte_ready) or flag underrun
// FIELD        | shifting token field or current data byte
// CEND         | crc_end strobe
// WAIT_CRC     | waiting for crc_done
// WAIT_LINE    | waiting for line_done (EOP on the wire)
module usb_tx_sequencer
    import usb_pkg::*;
#(
    parameter  int MAX_BYTES = 64,
    parameter  int TIMEOUT   = 255,
    localparam int LW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_req,
    output logic          tx_ready,
    input  logic [1:0]    tx_kind,
    input  logic [3:0]    tx_pid,
    input  logic [6:0]    tx_addr,
    input  logic [3:0]    tx_endp,
    input  logic [LW-1:0] tx_len,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [1:0]    pkt_in,
    output logic          crc_start,
    output logic          crc_end,
    output logic          bit_out,
    output logic          bit_valid,
    input  logic          pause,
    input  logic          crc_done,
    input  logic          line_done,
    output logic          eop_req,
    output logic          err_underrun,
    output logic          err_timeout
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_INIT = TW'(TIMEOUT - 1);

    tx_state_t     state, state_nxt;
    pkt_kind_t     kind_q;
    logic [3:0]    pid_q;
    logic [6:0]    addr_q;
    logic [3:0]    endp_q;
    logic [LW-1:0] len_q;
    logic [3:0]    bit_cnt;
    logic [LW-1:0] byte_cnt;
    logic [TW-1:0] tmr;

    logic          bit_state, adv, last_bit, in_wait, sh_bit;
    logic          latch, sh_load, cnt_load, byte_clr, byte_inc, tmr_load;
    logic [15:0]   sh_data;
    logic [3:0]    cnt_val;

    assign bit_state = (state == ST_SYNC) || (state == ST_PID) || (state == ST_FIELD);
    assign adv       = bit_state && !pause;
    assign last_bit  = (bit_cnt == 4'd0);
    assign in_wait   = (state == ST_WAIT_CRC) || (state == ST_WAIT_LINE);

    assign tx_ready  = (state == ST_IDLE);
    assign bit_valid = bit_state;
    assign bit_out   = bit_state & sh_bit;

    usb_tx_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_data (sh_data),
        .advance   (adv),
        .bit_out   (sh_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        latch        = 1'b0;
        sh_load      = 1'b0;
        sh_data      = '0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        byte_clr     = 1'b0;
        byte_inc     = 1'b0;
        tmr_load     = 1'b0;
        byte_ready   = 1'b0;
        pkt_in       = 2'b00;
        crc_start    = 1'b0;
        crc_end      = 1'b0;
        eop_req      = 1'b0;
        err_underrun = 1'b0;
        err_timeout  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_req && tx_kind != 2'b00) begin
                    latch     = 1'b1;
                    sh_load   = 1'b1;
                    sh_data   = {8'h00, SYNC_PATTERN};
                    cnt_load  = 1'b1;
                    cnt_val   = 4'd7;
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (adv && last_bit) begin
                    sh_load   = 1'b1;
                    sh_data   = {8'h00, pid_byte(pid_q)};
                    cnt_load  = 1'b1;
                    cnt_val   = 4'd7;
                    state_nxt = ST_PID;
                end
            end
            ST_PID: begin
                if (adv && last_bit) begin
                    if (kind_q == KIND_HANDSHAKE) begin
                        eop_req   = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = ST_WAIT_LINE;
                    end else begin
                        state_nxt = ST_CSTART;
                    end
                end
            end
            ST_CSTART: begin
                crc_start = 1'b1;
                pkt_in    = kind_q;
                byte_clr  = 1'b1;
                if (kind_q == KIND_TOKEN) begin
                    sh_load   = 1'b1;
                    sh_data   = {5'b0, endp_q, addr_q};
                    cnt_load  = 1'b1;
                    cnt_val   = 4'(TOKEN_FIELD_BITS - 1);
                    state_nxt = ST_FIELD;
                end else if (len_q == '0) begin
                    state_nxt = ST_CEND;
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (byte_valid) begin
                    byte_ready = 1'b1;
                    byte_inc   = 1'b1;
                    sh_load    = 1'b1;
                    sh_data    = {8'h00, byte_data};
                    cnt_load   = 1'b1;
                    cnt_val    = 4'd7;
                    state_nxt  = ST_FIELD;
                end else begin
                    // Abort: the CRC frame is left open, EOP closes the packet on the line.
                    err_underrun = 1'b1;
                    eop_req      = 1'b1;
                    tmr_load     = 1'b1;
                    state_nxt    = ST_WAIT_LINE;
                end
            end
            ST_FIELD: begin
                if (adv && last_bit) begin
                    if (kind_q == KIND_DATA && byte_cnt != len_q) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_CEND;
                    end
                end
            end
            ST_CEND: begin
                crc_end   = 1'b1;
                tmr_load  = 1'b1;
                state_nxt = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                if (crc_done && line_done) begin
                    state_nxt = ST_IDLE;
                end else if (crc_done) begin
                    tmr_load  = 1'b1;
                    state_nxt = ST_WAIT_LINE;
                end else if (tmr == '0) begin
                    err_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_LINE: begin
                if (line_done) begin
                    state_nxt = ST_IDLE;
                end else if (tmr == '0) begin
                    err_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= KIND_NONE;
            pid_q    <= '0;
            addr_q   <= '0;
            endp_q   <= '0;
            len_q    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tmr      <= '0;
        end else begin
            if (latch) begin
                kind_q <= pkt_kind_t'(tx_kind);
                pid_q  <= tx_pid;
                addr_q <= tx_addr;
                endp_q <= tx_endp;
                len_q  <= tx_len;
            end

            // Bit counter stops at zero; only a reload moves it off terminal count.
            if (cnt_load) begin
                bit_cnt <= cnt_val;
            end else if (adv && bit_cnt != 4'd0) begin
                bit_cnt <= bit_cnt - 4'd1;
            end

            if (byte_clr) begin
                byte_cnt <= '0;
            end else if (byte_inc) begin
                byte_cnt <= byte_cnt + LW'(1);
            end

            if (tmr_load) begin
                tmr <= TMR_INIT;
            end else if (in_wait && tmr != '0) begin
                tmr <= tmr - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Randomised bench for usb_tx_sequencer: expected wire bits, strobes and timeouts come from
// a packet-level model (bit queue plus event counts) built from the request alone.
module tb_usb_tx_sequencer;
    localparam int MAX_BYTES = 64;
    localparam int TIMEOUT   = 255;
    localparam int LW        = $clog2(MAX_BYTES + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_req, tx_ready;
    logic [1:0]    tx_kind;
    logic [3:0]    tx_pid;
    logic [6:0]    tx_addr;
    logic [3:0]    tx_endp;
    logic [LW-1:0] tx_len;
    logic [7:0]    byte_data;
    logic          byte_valid, byte_ready;
    logic [1:0]    pkt_in;
    logic          crc_start, crc_end, bit_out, bit_valid;
    logic          pause, crc_done, line_done;
    logic          eop_req, err_underrun, err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pay[$];

    usb_tx_sequencer #(.MAX_BYTES(MAX_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_ready(tx_ready),
        .tx_kind(tx_kind), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_len(tx_len), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .pkt_in(pkt_in), .crc_start(crc_start),
        .crc_end(crc_end), .bit_out(bit_out), .bit_valid(bit_valid), .pause(pause),
        .crc_done(crc_done), .line_done(line_done), .eop_req(eop_req),
        .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        tx_req = 0; tx_kind = 0; tx_pid = 0; tx_addr = 0; tx_endp = 0; tx_len = 0;
        byte_data = 0; byte_valid = 0; pause = 0; crc_done = 0; line_done = 0;
    endtask

    function automatic logic [10:0] quiet_outputs();
        return {bit_valid, bit_out, byte_ready, pkt_in, crc_start, crc_end,
                eop_req, err_underrun, err_timeout, ~tx_ready};
    endfunction

    // crc_delay / line_delay < 0 means the event never arrives.
    task automatic run_packet(input logic [1:0] kind, input logic [3:0] pid,
                              input logic [6:0] addr, input logic [3:0] endp,
                              input int len, input int underrun_idx, input int pause_mode,
                              input int crc_delay, input int line_delay, input bit both);
        bit exp_q[$];
        logic [7:0] pb;
        int nb, field_n, cyc, cs_at, crc_at, line_at, to, bidx, fbits, hold;
        int n_cs, n_ce, n_br, n_eop, n_und, n_to;
        bit done, in_field, prev_paused, prev_bit, exp_ce, exp_to;

        for (int i = 0; i < 7; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        pb = {~pid, pid};
        for (int i = 0; i < 8; i++) exp_q.push_back(pb[i]);
        nb = 0;
        field_n = 0;
        if (kind == 2'b01) begin
            for (int i = 0; i < 7; i++) exp_q.push_back(addr[i]);
            for (int i = 0; i < 4; i++) exp_q.push_back(endp[i]);
            field_n = 11;
        end else if (kind == 2'b10) begin
            nb = (underrun_idx >= 0) ? underrun_idx : len;
            for (int b = 0; b < nb; b++)
                for (int i = 0; i < 8; i++) exp_q.push_back(pay[b][i]);
            field_n = 8 * nb;
        end
        exp_ce = (kind == 2'b01) || (kind == 2'b10 && underrun_idx < 0);
        exp_to = exp_ce ? (crc_delay < 0 || (!both && line_delay < 0)) : (line_delay < 0);

        @(negedge clk);
        tx_req = 1; tx_kind = kind; tx_pid = pid; tx_addr = addr; tx_endp = endp;
        tx_len = LW'(len);
        #1 check("ready_before_accept", tx_ready, 1);

        cyc = 0; cs_at = -100; crc_at = -1; line_at = -1; to = -1; bidx = 0; fbits = 0;
        hold = 0; n_cs = 0; n_ce = 0; n_br = 0; n_eop = 0; n_und = 0; n_to = 0;
        done = 0; in_field = 0; prev_paused = 0; prev_bit = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            tx_req = (tx_ready == 1'b0) && ($urandom_range(0, 3) == 0);
            tx_kind = 2'($urandom_range(0, 3));
            tx_pid = 4'($urandom); tx_addr = 7'($urandom); tx_len = LW'($urandom_range(0, 9));
            if (pause_mode == 1) begin
                pause = ($urandom_range(0, 2) == 0);
            end else if (pause_mode == 2 && in_field && fbits == 4 && hold < 3) begin
                pause = 1; hold++;
            end else begin
                pause = 0;
            end
            byte_data  = (bidx < pay.size()) ? pay[bidx] : 8'($urandom);
            byte_valid = (bidx != underrun_idx);
            crc_done   = (cyc == crc_at);
            line_done  = (cyc == line_at) || (both && cyc == crc_at);
            if (cyc == crc_at && !both) begin
                if (line_delay >= 0) line_at = cyc + 1 + line_delay;
                else to = cyc + TIMEOUT;
            end
            #1;
            if (prev_paused) check("pause_hold", {bit_valid, bit_out}, {1'b1, prev_bit});
            if (bit_valid && !pause) begin
                if (exp_q.size() == 0) check("extra_bit", 0, 1);
                else check("bit", bit_out, exp_q.pop_front());
                if (in_field) fbits++;
            end
            prev_paused = bit_valid && pause;
            prev_bit    = bit_out;
            if (crc_start) begin
                n_cs++;
                check("pkt_in", pkt_in, kind);
                check("bits_before_field", exp_q.size(), field_n);
                cs_at = cyc; in_field = 1;
            end else if (pkt_in != 2'b00) begin
                check("pkt_in_quiet", pkt_in, 0);
            end
            if (crc_end) begin
                n_ce++;
                if (kind == 2'b10 && len == 0) check("cend_after_cstart", cyc - cs_at, 1);
                check("bits_at_cend", exp_q.size(), 0);
                in_field = 0;
                if (crc_delay >= 0) crc_at = cyc + 1 + crc_delay;
                else to = cyc + TIMEOUT;
            end
            if (byte_ready) begin
                n_br++;
                check("byte_ready_valid", byte_valid, 1);
                bidx++;
            end
            if (eop_req) begin
                n_eop++;
                if (line_delay >= 0) line_at = cyc + 1 + line_delay;
                else to = cyc + TIMEOUT;
            end
            if (err_underrun) n_und++;
            if (err_timeout || (to >= 0 && cyc == to)) check("timeout_cycle", err_timeout, cyc == to);
            if (err_timeout) n_to++;
            if (tx_ready) done = 1;
        end
        tx_req = 0; pause = 0; crc_done = 0; line_done = 0;
        check("ready_end", tx_ready, 1);
        check("bits_left", exp_q.size(), 0);
        check("n_crc_start", n_cs, (kind != 2'b11) ? 1 : 0);
        check("n_crc_end", n_ce, exp_ce ? 1 : 0);
        check("n_byte_ready", n_br, nb);
        check("n_eop_req", n_eop, (kind == 2'b11 || underrun_idx >= 0) ? 1 : 0);
        check("n_underrun", n_und, (underrun_idx >= 0) ? 1 : 0);
        check("n_timeout", n_to, exp_to ? 1 : 0);
    endtask

    task automatic fill_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        int len, und;
        bit seen;
        clear_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", quiet_outputs(), 0);
        rst_n = 1;

        // kind 00 is dropped
        @(negedge clk);
        tx_req = 1; tx_kind = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("kind00_ignored", quiet_outputs(), 0);
        end
        tx_req = 0;

        pay.delete();
        run_packet(2'b01, 4'b0001, 7'h05, 4'h0, 0, -1, 0, 2, 3, 0);
        run_packet(2'b01, 4'b1001, 7'h5A, 4'h9, 0, -1, 2, 1, 1, 0);
        run_packet(2'b10, 4'b0011, 7'h00, 4'h0, 0, -1, 0, 0, 0, 0);
        pay.delete(); pay.push_back(8'hA5); pay.push_back(8'h3C);
        run_packet(2'b10, 4'b1011, 7'h00, 4'h0, 2, -1, 1, 1, 2, 0);
        run_packet(2'b11, 4'b0010, 7'h00, 4'h0, 0, -1, 0, 0, 4, 0);
        fill_pay(3);
        run_packet(2'b10, 4'b0011, 7'h00, 4'h0, 3, 1, 1, 0, 2, 0);
        run_packet(2'b01, 4'b1101, 7'h11, 4'h2, 0, -1, 0, 0, -1, 0);
        fill_pay(1);
        run_packet(2'b10, 4'b0011, 7'h00, 4'h0, 1, -1, 0, -1, 0, 0);
        run_packet(2'b11, 4'b1010, 7'h00, 4'h0, 0, -1, 1, 0, -1, 0);
        run_packet(2'b01, 4'b1001, 7'h7F, 4'hF, 0, -1, 1, 3, 0, 1);
        fill_pay(MAX_BYTES);
        run_packet(2'b10, 4'b1011, 7'h00, 4'h0, MAX_BYTES, -1, 1, 0, 0, 0);

        // asynchronous reset mid-field
        @(negedge clk);
        tx_req = 1; tx_kind = 2'b01; tx_pid = 4'b0001; tx_addr = 7'h2B; tx_endp = 4'h3;
        @(negedge clk);
        tx_req = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1 seen = crc_start;
        end
        check("reset_test_cstart", seen, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1 check("async_reset_outputs", quiet_outputs(), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1 check("ready_after_reset", quiet_outputs(), 0);

        for (int p = 0; p < 20; p++) begin
            logic [1:0] k;
            k = 2'($urandom_range(1, 3));
            len = ($urandom_range(0, 9) == 0) ? MAX_BYTES : $urandom_range(0, 6);
            und = (k == 2'b10 && len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            fill_pay(len);
            run_packet(k, 4'($urandom), 7'($urandom), 4'($urandom), len, und, 1,
                       $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
